// File: rtl/st2mm_pingpong_if.sv
// Avalon-ST sink bundle and Avalon-MM write-master bundle used by st2mm_pingpong.
interface st2mm_st_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
);
    logic [DATA_W-1:0]  data_in_data;
    logic               data_in_valid;
    logic               data_in_ready;
    logic [EMPTY_W-1:0] data_in_empty;
    logic               data_in_startofpacket;
    logic               data_in_endofpacket;

    modport master (
        output data_in_data,
        output data_in_valid,
        output data_in_empty,
        output data_in_startofpacket,
        output data_in_endofpacket,
        input  data_in_ready
    );

    modport slave (
        input  data_in_data,
        input  data_in_valid,
        input  data_in_empty,
        input  data_in_startofpacket,
        input  data_in_endofpacket,
        output data_in_ready
    );
endinterface

interface st2mm_mm_if #(
    parameter int DATA_W  = 32,
    parameter int BANK_AW = 8
);
    logic [BANK_AW:0]  mm_address;
    logic              mm_chipselect;
    logic              mm_write;
    logic [DATA_W-1:0] mm_writedata;
    logic              mm_waitrequest_n;

    modport master (
        output mm_address,
        output mm_chipselect,
        output mm_write,
        output mm_writedata,
        input  mm_waitrequest_n
    );

    modport slave (
        input  mm_address,
        input  mm_chipselect,
        input  mm_write,
        input  mm_writedata,
        output mm_waitrequest_n
    );
endinterface

// File: rtl/st2mm_pingpong.sv
// Writes Avalon-ST frames alternately into two banks of an Avalon-MM RAM at {bank, word_index};
// a bank stays locked until the consumer releases it, and frames aimed at a locked bank are dropped.
module st2mm_pingpong #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int BANK_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    st2mm_st_if.slave          st,
    st2mm_mm_if.master         mm,
    input  logic [1:0]         bank_release,
    output logic [1:0]         bank_full,
    output logic               frame_done,
    output logic               frame_bank,
    output logic [BANK_AW:0]   frame_len,
    output logic [EMPTY_W-1:0] frame_empty,
    output logic               frame_trunc,
    output logic [15:0]        drop_count
);
    localparam int               DEPTH    = 2 ** BANK_AW;
    localparam logic [BANK_AW:0] LAST_IDX = (BANK_AW + 1)'(DEPTH - 1);
    localparam logic [BANK_AW:0] CTR_ONE  = (BANK_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DISCARD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_wr_bank;
    logic [BANK_AW:0]   r_ctr;
    logic [1:0]         r_bank_full;
    logic [15:0]        r_drop_count;
    logic               r_trunc_flag;
    logic [EMPTY_W-1:0] r_empty_lat;

    logic               r_frame_bank;
    logic [BANK_AW:0]   r_frame_len;
    logic [EMPTY_W-1:0] r_frame_empty;
    logic               r_frame_trunc;

    logic               w_ready;
    logic               w_write;
    logic               w_ctr_load1;
    logic               w_ctr_inc;
    logic               w_latch_empty;
    logic               w_trunc_set;
    logic               w_trunc_clr;
    logic               w_drop;
    logic               w_commit;
    logic [1:0]         w_set_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets its default first, so no branch can infer a latch.
        w_state_nxt   = r_state;
        w_ready       = 1'b1;
        w_write       = 1'b0;
        w_ctr_load1   = 1'b0;
        w_ctr_inc     = 1'b0;
        w_latch_empty = 1'b0;
        w_trunc_set   = 1'b0;
        w_trunc_clr   = 1'b0;
        w_drop        = 1'b0;
        w_commit      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // Non-SOP beats are swallowed here with ready held high.
                if (st.data_in_valid && st.data_in_startofpacket) begin
                    w_trunc_clr = 1'b1;
                    if (!r_bank_full[r_wr_bank]) begin
                        w_write = 1'b1;
                        w_ready = mm.mm_waitrequest_n;
                        if (mm.mm_waitrequest_n) begin
                            w_ctr_load1 = 1'b1;
                            if (st.data_in_endofpacket) begin
                                w_latch_empty = 1'b1;
                                w_state_nxt   = S_DONE;
                            end else begin
                                w_state_nxt = S_WRITE;
                            end
                        end
                    end else begin
                        w_drop = 1'b1;
                        if (!st.data_in_endofpacket) begin
                            w_state_nxt = S_DISCARD;
                        end
                    end
                end
            end

            S_WRITE: begin
                w_write = st.data_in_valid;
                w_ready = mm.mm_waitrequest_n;
                if (st.data_in_valid && mm.mm_waitrequest_n) begin
                    w_ctr_inc = 1'b1;
                    if (st.data_in_endofpacket) begin
                        w_latch_empty = 1'b1;
                        w_state_nxt   = S_DONE;
                    end else if (r_ctr == LAST_IDX) begin
                        w_trunc_set = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                if (st.data_in_valid && st.data_in_endofpacket) begin
                    if (r_trunc_flag) begin
                        w_latch_empty = 1'b1;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DONE: begin
                w_ready     = 1'b0;
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A commit sets the current bank; it overrides a release of that bank in the same cycle.
    assign w_set_mask = {r_wr_bank, ~r_wr_bank} & {2{w_commit}};

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_ctr         <= '0;
            r_bank_full   <= '0;
            r_drop_count  <= '0;
            r_trunc_flag  <= 1'b0;
            r_empty_lat   <= '0;
            r_frame_bank  <= 1'b0;
            r_frame_len   <= '0;
            r_frame_empty <= '0;
            r_frame_trunc <= 1'b0;
        end else begin
            if (w_commit) begin
                r_ctr <= '0;
            end else if (w_ctr_load1) begin
                r_ctr <= CTR_ONE;
            end else if (w_ctr_inc) begin
                r_ctr <= r_ctr + CTR_ONE;
            end

            if (w_trunc_clr) begin
                r_trunc_flag <= 1'b0;
            end else if (w_trunc_set) begin
                r_trunc_flag <= 1'b1;
            end

            if (w_latch_empty) begin
                r_empty_lat <= st.data_in_empty;
            end

            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            r_bank_full <= (r_bank_full & ~bank_release) | w_set_mask;

            if (w_commit) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_bank  <= r_wr_bank;
                r_frame_len   <= r_ctr;
                r_frame_empty <= r_empty_lat;
                r_frame_trunc <= r_trunc_flag;
            end
        end
    end

    // The committing frame is visible during the frame_done cycle and held afterwards.
    assign frame_done  = (r_state == S_DONE);
    assign frame_bank  = frame_done ? r_wr_bank    : r_frame_bank;
    assign frame_len   = frame_done ? r_ctr        : r_frame_len;
    assign frame_empty = frame_done ? r_empty_lat  : r_frame_empty;
    assign frame_trunc = frame_done ? r_trunc_flag : r_frame_trunc;

    assign bank_full  = r_bank_full;
    assign drop_count = r_drop_count;

    assign st.data_in_ready = w_ready;
    assign mm.mm_write      = w_write;
    assign mm.mm_chipselect = w_write;
    assign mm.mm_address    = {r_wr_bank, r_ctr[BANK_AW-1:0]};
    assign mm.mm_writedata  = st.data_in_data;
endmodule

// File: tb/tb_st2mm_pingpong.sv
// Directed-plus-random bench for st2mm_pingpong with BANK_AW=3; a frame-level model
// predicts MM writes, committed frames, bank locks and the drop counter.
module tb_st2mm_pingpong;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
    localparam int BANK_AW = 3;
    localparam int DEPTH   = 8;

    typedef struct packed {
        logic [BANK_AW:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic               bank;
        logic [BANK_AW:0]   len;
        logic [EMPTY_W-1:0] empty;
        logic               trunc;
    } frm_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         bank_release;
    logic [1:0]         bank_full;
    logic               frame_done;
    logic               frame_bank;
    logic [BANK_AW:0]   frame_len;
    logic [EMPTY_W-1:0] frame_empty;
    logic               frame_trunc;
    logic [15:0]        drop_count;

    st2mm_st_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) st ();
    st2mm_mm_if #(.DATA_W(DATA_W), .BANK_AW(BANK_AW)) mm ();

    st2mm_pingpong #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .BANK_AW(BANK_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .st           (st),
        .mm           (mm),
        .bank_release (bank_release),
        .bank_full    (bank_full),
        .frame_done   (frame_done),
        .frame_bank   (frame_bank),
        .frame_len    (frame_len),
        .frame_empty  (frame_empty),
        .frame_trunc  (frame_trunc),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed traffic, sampled on the falling edge.
    wr_t  wr_q[$];
    frm_t done_q[$];
    int   n_notready = 0;
    int   n_wrcyc    = 0;

    // Frame-level reference model.
    logic [1:0]        m_full;
    logic              m_bank;
    logic [15:0]       m_drop;
    frm_t              m_frame;
    wr_t               exp_wr[$];
    frm_t              exp_done[$];
    logic [DATA_W-1:0] beats[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mm.mm_write) begin
                n_wrcyc++;
                chk("mm_chipselect_and_data", {31'd0, mm.mm_chipselect, mm.mm_writedata},
                    {31'd0, 1'b1, st.data_in_data});
            end
            if (mm.mm_write && mm.mm_waitrequest_n)
                wr_q.push_back(wr_t'{mm.mm_address, mm.mm_writedata});
            if (st.data_in_valid && !st.data_in_ready)
                n_notready++;
            if (frame_done)
                done_q.push_back(frm_t'{frame_bank, frame_len, frame_empty, frame_trunc});
        end
    end

    task automatic idle_inputs();
        st.data_in_valid         = 1'b0;
        st.data_in_startofpacket = 1'b0;
        st.data_in_endofpacket   = 1'b0;
        st.data_in_empty         = '0;
    endtask

    // Drives n beats; optionally holds waitrequest_n low for stall_len cycles on beat stall_at.
    task automatic send_beats(input int n, input bit sop_first, input bit eop_last, input int empty,
                              input bit directed, input logic [DATA_W-1:0] base,
                              input int stall_at, input int stall_len);
        logic [BANK_AW:0] addr0;
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            st.data_in_valid         = 1'b1;
            st.data_in_data          = directed ? base + DATA_W'(i) : DATA_W'($urandom);
            st.data_in_startofpacket = sop_first && (i == 0);
            st.data_in_endofpacket   = eop_last && (i == n - 1);
            st.data_in_empty         = st.data_in_endofpacket ? EMPTY_W'(empty)
                                                              : EMPTY_W'($urandom_range(0, 3));
            beats.push_back(st.data_in_data);
            if (i == stall_at) begin
                mm.mm_waitrequest_n = 1'b0;
                addr0 = {m_bank, BANK_AW'(stall_at)};
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_ready_low", {63'd0, st.data_in_ready}, 64'd0);
                    chk("stall_write_held", {63'd0, mm.mm_write}, 64'd1);
                    chk("stall_addr_held", {60'd0, mm.mm_address}, {60'd0, addr0});
                    chk("stall_data_held", {32'd0, mm.mm_writedata}, {32'd0, st.data_in_data});
                    @(posedge clk);
                    #1;
                end
                mm.mm_waitrequest_n = 1'b1;
            end
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 40) begin
                @(negedge clk);
                acc = st.data_in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            chk("beat_accept", {63'd0, acc}, 64'd1);
        end
        idle_inputs();
    endtask

    // Frame-level prediction: a free bank receives min(n, DEPTH) words, otherwise the frame is dropped.
    task automatic model_packet(input int n, input int empty);
        int kept;
        if (m_full[m_bank]) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
            kept = (n > DEPTH) ? DEPTH : n;
            for (int i = 0; i < kept; i++)
                exp_wr.push_back(wr_t'{{m_bank, BANK_AW'(i)}, beats[i]});
            m_frame = frm_t'{m_bank, (BANK_AW + 1)'(kept), EMPTY_W'(empty), (n > DEPTH)};
            exp_done.push_back(m_frame);
            m_full[m_bank] = 1'b1;
            m_bank = ~m_bank;
        end
    endtask

    task automatic do_release(input logic [1:0] rel);
        bank_release = rel;
        @(posedge clk);
        #1;
        bank_release = 2'b00;
        m_full = m_full & ~rel;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s.wr_count", tag), 64'(wr_q.size()), 64'(exp_wr.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_wr[i]));
        chk($sformatf("%s.done_count", tag), 64'(done_q.size()), 64'(exp_done.size()));
        for (int i = 0; i < done_q.size() && i < exp_done.size(); i++)
            chk($sformatf("%s.frame_at_done%0d", tag, i), 64'(done_q[i]), 64'(exp_done[i]));
        chk($sformatf("%s.bank_full", tag), 64'(bank_full), 64'(m_full));
        chk($sformatf("%s.drop_count", tag), 64'(drop_count), 64'(m_drop));
        chk($sformatf("%s.frame_held", tag),
            64'(frm_t'{frame_bank, frame_len, frame_empty, frame_trunc}), 64'(m_frame));
        chk($sformatf("%s.frame_done_idle", tag), {63'd0, frame_done}, 64'd0);
        wr_q.delete();
        exp_wr.delete();
        done_q.delete();
        exp_done.delete();
    endtask

    task automatic run_pkt(input string tag, input int n, input int empty, input bit directed,
                           input logic [DATA_W-1:0] base, input int stall_at, input int stall_len);
        beats.delete();
        send_beats(n, 1'b1, 1'b1, empty, directed, base, stall_at, stall_len);
        model_packet(n, empty);
        settle();
        check_all(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".bank_full"}, 64'(bank_full), 64'd0);
        chk({tag, ".drop_count"}, 64'(drop_count), 64'd0);
        chk({tag, ".frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, ".frame_fields"},
            64'(frm_t'{frame_bank, frame_len, frame_empty, frame_trunc}), 64'd0);
        chk({tag, ".mm_write"}, {63'd0, mm.mm_write}, 64'd0);
    endtask

    initial begin
        int nw0;
        int nr0;
        int n;
        int stall;
        logic [1:0] rel;

        rst                 = 1'b1;
        bank_release        = 2'b00;
        st.data_in_data     = '0;
        mm.mm_waitrequest_n = 1'b1;
        idle_inputs();
        m_full  = 2'b00;
        m_bank  = 1'b0;
        m_drop  = '0;
        m_frame = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: five beats 0x10..0x14 into bank 0.
        run_pkt("t1_five", 5, 0, 1'b1, 32'h10, -1, 0);

        // 2: three beats with empty=2 into bank 1.
        run_pkt("t2_three", 3, 2, 1'b0, '0, -1, 0);

        // 3: both banks locked, frame is dropped with ready held high and no writes.
        nw0 = n_wrcyc;
        nr0 = n_notready;
        run_pkt("t3_drop", 4, 1, 1'b0, '0, -1, 0);
        chk("t3_no_write_cycles", 64'(n_wrcyc - nw0), 64'd0);
        chk("t3_never_not_ready", 64'(n_notready - nr0), 64'd0);
        do_release(2'b01);
        chk("t3_after_release", 64'(bank_full), 64'(m_full));
        run_pkt("t3_next", 2 + int'($urandom_range(0, 4)), 3, 1'b0, '0, -1, 0);

        // 4: overlong frame is truncated at DEPTH; an exact-DEPTH frame is not.
        do_release(2'b10);
        run_pkt("t4_trunc", 11, 3, 1'b0, '0, -1, 0);
        do_release(2'b01);
        run_pkt("t4_exact", DEPTH, 1, 1'b0, '0, -1, 0);

        // 5: three-cycle backpressure in mid-packet.
        do_release(2'b10);
        run_pkt("t5_stall", 6, 0, 1'b0, '0, 3, 3);

        // Single-beat frame whose commit coincides with a release of the same bank.
        do_release(2'b01);
        beats.delete();
        send_beats(1, 1'b1, 1'b1, 1, 1'b0, '0, -1, 0);
        bank_release = 2'b01;
        @(posedge clk);
        #1;
        bank_release = 2'b00;
        model_packet(1, 1);
        settle();
        check_all("t5_collide");

        // Random frames, random releases, occasional stalls.
        for (int k = 0; k < 8; k++) begin
            rel = 2'($urandom_range(0, 3));
            do_release(rel);
            n = int'($urandom_range(1, 11));
            stall = -1;
            if (!m_full[m_bank] && $urandom_range(0, 1) == 1)
                stall = int'($urandom_range(0, ((n > DEPTH) ? DEPTH : n) - 1));
            run_pkt($sformatf("rnd%0d", k), n, int'($urandom_range(0, 3)), 1'b0, '0, stall,
                    int'($urandom_range(1, 3)));
        end

        // 6: reset after two beats of a frame.
        do_release(2'b11);
        beats.delete();
        send_beats(2, 1'b1, 1'b0, 0, 1'b0, '0, -1, 0);
        @(negedge clk);
        chk("t6_partial_writes", 64'(wr_q.size()), 64'd2);
        for (int i = 0; i < wr_q.size() && i < 2; i++)
            chk($sformatf("t6_partial_wr%0d", i), 64'(wr_q[i]),
                64'(wr_t'{{m_bank, BANK_AW'(i)}, beats[i]}));
        wr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_zero_outputs("t6_in_reset");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_full  = 2'b00;
        m_bank  = 1'b0;
        m_drop  = '0;
        m_frame = '0;
        settle();
        check_all("t6_after_reset");

        beats.delete();
        send_beats(3, 1'b0, 1'b1, 2, 1'b0, '0, -1, 0);
        settle();
        check_all("t6_stray");
        run_pkt("t6_fresh", 4, 1, 1'b0, '0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/st2mm_pingpong.md
Name: st2mm_pingpong

Overview:
Parametrised successor to the single-buffer stream-to-memory writer. Accepts Avalon-ST packets (sensor frames) and writes each one into one of two ping-pong banks of an Avalon-MM on-chip RAM. The bank mapping is address = {bank, word_index}. Completed frames are reported with length, bank and error status. The consumer (Nios/DMA) frees each bank explicitly, so a frame is never overwritten before it is read. Sits between the sensor algorithm stream output and the dual-port result RAM.

Parameters:
DATA_W, 32, stream/MM data width
EMPTY_W, 2, width of data_in_empty
BANK_AW, 8, word-address width of one bank; DEPTH = 2**BANK_AW words per bank

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
data_in_data  in  DATA_W  ST data
data_in_valid  in  1  ST valid
data_in_ready  out  1  ST ready (readyLatency 0)
data_in_empty  in  EMPTY_W  ST empty, meaningful on EOP beat
data_in_startofpacket  in  1  ST SOP
data_in_endofpacket  in  1  ST EOP
mm_address  out  BANK_AW+1  word address, MSB = bank
mm_chipselect  out  1  equals mm_write
mm_write  out  1  write strobe
mm_writedata  out  DATA_W  equals data_in_data
mm_waitrequest_n  in  1  slave ready
bank_release  in  2  one-cycle pulse per bank; frees that bank
bank_full  out  2  bank holds an unreleased frame
frame_done  out  1  one-cycle pulse when a frame is committed
frame_bank  out  1  bank of last committed frame
frame_len  out  BANK_AW+1  words written in last frame (1..DEPTH)
frame_empty  out  EMPTY_W  empty value from last frame's EOP beat
frame_trunc  out  1  last frame exceeded DEPTH and was truncated
drop_count  out  16  packets dropped because the target bank was full; saturates at 0xFFFF

Behaviour:
- Beat accepted = data_in_valid & data_in_ready. An MM write completes when mm_write & mm_waitrequest_n.
- Reset (any state, mid-packet included): state IDLE, wr_bank=0, ctr=0, bank_full=0, drop_count=0, all frame_* and frame_done 0. A partial frame is abandoned with no frame_done.
- States: IDLE, WRITE, DISCARD, DONE.
- IDLE (ready=1 unless writing):
  - Beat without SOP: consumed and ignored, no write.
  - SOP beat, bank_full[wr_bank]=0: mm_write=valid, address {wr_bank,0}, ready=mm_waitrequest_n. On accept, ctr<=1. If EOP on the same beat -> DONE; else -> WRITE.
  - SOP beat, bank_full[wr_bank]=1: ready=1, no write, drop_count++. If EOP -> stay IDLE; else -> DISCARD with trunc_flag=0.
- WRITE:
  - mm_write=valid, address {wr_bank,ctr[BANK_AW-1:0]}, ready=mm_waitrequest_n. Each accept does ctr++.
  - Accept with EOP -> DONE; latch empty.
  - Accept of the word at index DEPTH-1 without EOP -> DISCARD with trunc_flag=1.
  - SOP mid-packet is ignored; the beat is written as data.
- DISCARD: ready=1, no writes. On an EOP accept: if trunc_flag, latch empty -> DONE; else -> IDLE.
- DONE (exactly one cycle, ready=0, mm_write=0):
  - frame_done=1; frame_bank=wr_bank; frame_len=ctr; frame_trunc=trunc_flag; frame_empty=latched empty.
  - bank_full[wr_bank]<=1; wr_bank toggles; ctr<=0; -> IDLE.
- frame_* outputs hold until the next DONE.
- bank_release[b] clears bank_full[b] on the next edge. If release and DONE set the same bank in the same cycle, set wins. Releasing a non-full bank has no effect.
- Write latency: data appears on the MM bus in the same cycle as the accept. There is no internal buffering, and backpressure is passed straight through from mm_waitrequest_n.
- ctr is BANK_AW+1 bits wide and never exceeds DEPTH.

Test Plan (BANK_AW=3, DEPTH=8):
1. 5-beat packet, data 0x10..0x14, waitrequest_n=1 -> writes addr 0..4. Then frame_done with frame_bank=0, frame_len=5, frame_trunc=0, bank_full=01.
2. Second 3-beat packet with empty=2 -> writes addr 8..10; frame_bank=1, frame_len=3, frame_empty=2, bank_full=11.
3. Third packet while bank_full=11 -> no mm_write, ready=1 throughout, drop_count=1. Then pulse bank_release=01 -> bank_full=10, and the next packet writes addr 0.
4. 11-beat packet -> writes addr 0..7 only, remaining 3 beats consumed. frame_len=8, frame_trunc=1.
5. waitrequest_n low for 3 cycles mid-packet -> ready low for those cycles, address and data held, no beat lost or duplicated; frame_len is correct.
6. Assert rst after beat 2 of a packet -> all outputs 0, no frame_done. A fresh packet then writes from addr 0; stray non-SOP beats are ignored.
